// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU between two requesters.
// Operands are registered onto the ALU; the result is captured after ALU_LAT cycles and held until accepted.
module alu_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_sub,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_sub,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    output logic             alu_sub,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_status
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     r_state;
    logic       r_last;
    logic [3:0] r_cnt;
    logic       w_g0, w_g1;
    // rst_n gating keeps ready low while reset is held, even if valids are up
    assign w_g0 = rst_n && r_state == IDLE && req0_valid && (!req1_valid || r_last);
    assign w_g1 = rst_n && r_state == IDLE && req1_valid && (!req0_valid || !r_last);
    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_sub    <= 1'b0;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_status <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_g0 || w_g1) begin
                    alu_a      <= w_g1 ? req1_a : req0_a;
                    alu_b      <= w_g1 ? req1_b : req0_b;
                    alu_opcode <= w_g1 ? req1_op : req0_op;
                    alu_sub    <= w_g1 ? req1_sub : req0_sub;
                    alu_cin    <= w_g1 ? req1_cin : req0_cin;
                    r_last     <= w_g1;
                    r_cnt      <= 4'(ALU_LAT - 1);
                    r_state    <= EXEC;
                end
                EXEC: if (r_cnt == 4'd0) begin
                    rsp_result <= alu_result;
                    rsp_status <= alu_status;
                    rsp_id     <= r_last;
                    rsp_valid  <= 1'b1;
                    r_state    <= RESP;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: two arbiter instances (ALU_LAT 1 and 3) driven by a behavioural ALU,
// checked every cycle against a transaction-level model of grants, latency and responses.
module tb_alu_req_arbiter;
    logic        clk, rst_n;
    logic        req_valid[2][2], req_ready[2][2], req_sub[2][2], req_cin[2][2];
    logic [31:0] req_a[2][2], req_b[2][2];
    logic [2:0]  req_op[2][2];
    logic [31:0] alu_a[2], alu_b[2], alu_res[2], rsp_result[2];
    logic [2:0]  alu_op[2];
    logic        alu_sub[2], alu_cin[2], rsp_valid[2], rsp_ready[2], rsp_id[2];
    logic [3:0]  alu_st[2], rsp_status[2];

    int checks = 0, errors = 0, cyc = 0;
    bit          busy[2], last[2], eid[2], pid[2], ecin[2], esub[2];
    int          acc[2];
    logic [31:0] ea[2], eb[2], er[2], pr[2];
    logic [2:0]  eop[2];
    logic [3:0]  es[2], ps[2];

    function automatic logic [35:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic sub, logic cin);
        logic [32:0] s;
        logic [31:0] bb, r;
        logic [3:0]  st;
        bb = sub ? -b : b;
        s  = {1'b0, a} + {1'b0, bb} + 33'(cin);
        case (op)
            3'd0: r = s[31:0];
            3'd1: r = a ^ b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~(a | b);
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = '0;
        endcase
        st = {op == 3'd0 && a[31] == bb[31] && r[31] != a[31], op == 3'd0 && s[32], r[31], r == 32'd0};
        return {st, r};
    endfunction

    function automatic int lat_of(int k);
        return k == 0 ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        alu_req_arbiter #(.WIDTH(32), .ALU_LAT(k == 0 ? 1 : 3)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(req_valid[k][0]), .req0_ready(req_ready[k][0]), .req0_a(req_a[k][0]), .req0_b(req_b[k][0]),
            .req0_op(req_op[k][0]), .req0_sub(req_sub[k][0]), .req0_cin(req_cin[k][0]),
            .req1_valid(req_valid[k][1]), .req1_ready(req_ready[k][1]), .req1_a(req_a[k][1]), .req1_b(req_b[k][1]),
            .req1_op(req_op[k][1]), .req1_sub(req_sub[k][1]), .req1_cin(req_cin[k][1]),
            .alu_a(alu_a[k]), .alu_b(alu_b[k]), .alu_opcode(alu_op[k]), .alu_sub(alu_sub[k]), .alu_cin(alu_cin[k]),
            .alu_result(alu_res[k]), .alu_status(alu_st[k]),
            .rsp_valid(rsp_valid[k]), .rsp_ready(rsp_ready[k]), .rsp_id(rsp_id[k]),
            .rsp_result(rsp_result[k]), .rsp_status(rsp_status[k])
        );
        assign {alu_st[k], alu_res[k]} = alu_f(alu_a[k], alu_b[k], alu_op[k], alu_sub[k], alu_cin[k]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; last[k] = 1; pid[k] = 0; pr[k] = '0; ps[k] = '0;
            ea[k] = '0; eb[k] = '0; eop[k] = '0; esub[k] = 0; ecin[k] = 0;
        end
    endtask

    // One clock cycle: compare both instances to the model, predict the coming edge, advance.
    task automatic step();
        bit e0, e1, erv;
        #1;
        for (int k = 0; k < 2; k++) begin
            e0  = !busy[k] && req_valid[k][0] && (!req_valid[k][1] || last[k]);
            e1  = !busy[k] && req_valid[k][1] && (!req_valid[k][0] || !last[k]);
            erv = busy[k] && cyc >= acc[k] + 1 + lat_of(k);
            chk("ready0", k, req_ready[k][0], e0);
            chk("ready1", k, req_ready[k][1], e1);
            chk("rsp_valid", k, rsp_valid[k], erv);
            chk("alu_a", k, alu_a[k], ea[k]);
            chk("alu_b", k, alu_b[k], eb[k]);
            chk("alu_ctl", k, {alu_op[k], alu_sub[k], alu_cin[k]}, {eop[k], esub[k], ecin[k]});
            if (erv) begin
                pr[k] = er[k]; ps[k] = es[k]; pid[k] = eid[k];
            end
            chk("rsp_result", k, rsp_result[k], pr[k]);
            chk("rsp_status", k, rsp_status[k], ps[k]);
            chk("rsp_id", k, rsp_id[k], pid[k]);
            if (erv && rsp_ready[k]) busy[k] = 0;
            else if (e0 || e1) begin
                busy[k] = 1; acc[k] = cyc; last[k] = e1; eid[k] = e1;
                ea[k] = req_a[k][e1]; eb[k] = req_b[k][e1]; eop[k] = req_op[k][e1];
                esub[k] = req_sub[k][e1]; ecin[k] = req_cin[k][e1];
                {es[k], er[k]} = alu_f(ea[k], eb[k], eop[k], esub[k], ecin[k]);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic scramble(int k, int p);
        req_a[k][p] = $urandom; req_b[k][p] = $urandom; req_op[k][p] = 3'($urandom);
        req_sub[k][p] = 1'($urandom); req_cin[k][p] = 1'($urandom);
    endtask

    task automatic rand_run(int n, int pv, int pr_pct);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    req_valid[k][p] = $urandom_range(99) < pv;
                    scramble(k, p);
                end
                rsp_ready[k] = $urandom_range(99) < pr_pct;
            end
            step();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2; k++) begin
            req_valid[k][0] = 0; req_valid[k][1] = 0; rsp_ready[k] = 1;
        end
        repeat (8) step();
        rsp_ready[0] = 0; rsp_ready[1] = 0;
    endtask

    task automatic dop(int k, int p, logic [31:0] a, logic [31:0] b, logic [2:0] op, logic sub, logic cin,
                       logic [31:0] xr, logic [3:0] xs);
        int n;
        req_a[k][p] = a; req_b[k][p] = b; req_op[k][p] = op; req_sub[k][p] = sub; req_cin[k][p] = cin;
        req_valid[k][p] = 1; req_valid[k][1-p] = 0; rsp_ready[k] = 0;
        n = 0;
        while (!busy[k] && n < 20) begin step(); n++; end
        req_valid[k][p] = 0;
        scramble(k, p);
        n = 0;
        while (!rsp_valid[k] && n < 20) begin step(); n++; end
        chk("dir_valid", k, rsp_valid[k], 1);
        chk("dir_result", k, rsp_result[k], xr);
        chk("dir_status", k, rsp_status[k], xs);
        chk("dir_id", k, rsp_id[k], p);
        rsp_ready[k] = 1;
        step();
        rsp_ready[k] = 0;
    endtask

    initial begin
        int n;
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            rsp_ready[k] = 0;
            for (int p = 0; p < 2; p++) begin
                req_valid[k][p] = 0; scramble(k, p);
            end
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        mreset();
        // both ports held valid from reset: grants must alternate starting with port 0
        for (int i = 0; i < 24; i++) begin
            req_valid[0][0] = 1; req_valid[0][1] = 1; rsp_ready[0] = 1;
            scramble(0, 0); scramble(0, 1);
            step();
        end
        drain();
        dop(0, 0, 32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 32'd12, 4'b0000);
        dop(0, 1, 32'd3, 32'd5, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0010);
        dop(1, 0, 32'hF0F0, 32'h0FF0, 3'b001, 1'b0, 1'b0, 32'hFF00, 4'b0000);
        dop(1, 1, 32'h1234, 32'h5678, 3'b111, 1'b0, 1'b1, 32'd0, 4'b0001);
        // consumer stalls for a long stretch, then mixed traffic
        rand_run(15, 80, 0);
        rand_run(400, 60, 40);
        drain();
        // reset while instance 1 is mid-execution
        req_valid[1][1] = 1; scramble(1, 1);
        n = 0;
        while (!busy[1] && n < 20) begin step(); n++; end
        req_valid[1][1] = 0;
        step();
        for (int k = 0; k < 2; k++) begin
            req_valid[k][0] = 1; req_valid[k][1] = 1;
        end
        rst_n = 0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, {req_ready[k][0], req_ready[k][1]}, 0);
            chk("rst_alu", k, {alu_a[k], alu_b[k]}, 0);
            chk("rst_alu_ctl", k, {alu_op[k], alu_sub[k], alu_cin[k]}, 0);
            chk("rst_rsp", k, {rsp_valid[k], rsp_id[k], rsp_status[k], rsp_result[k]}, 0);
            req_valid[k][0] = 0; req_valid[k][1] = 0;
        end
        @(posedge clk);
        #3 rst_n = 1;
        mreset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k][0] = 1; req_valid[k][1] = 1; rsp_ready[k] = 0;
                scramble(k, 0); scramble(k, 1);
            end
            step();
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
